dmem_load_scheduler: RTL and testbench

- Shares the single load request/response port of the data-memory arbiter between NUM_REQ load requesters, e.g. the LSU load pipe and the page-table walker.
- Round-robin arbitration on the request side. Outstanding loads are tracked in a small table. Each response is routed back to its owner by address match.
- Sits directly in front of the dmem arbiter's load ports; the store port bypasses this block.

---
 rtl/dmem_load_scheduler_pkg.sv | 25 ++
 rtl/dmem_load_scheduler_rr_arbiter.sv | 33 +++
 rtl/dmem_load_scheduler.sv | 166 ++++++++++++++++
 tb/tb_dmem_load_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_load_scheduler_pkg.sv
// Shared types and constants for the data-memory load scheduler.
package dmem_load_scheduler_pkg;

   localparam int DMEM_XLEN            = 64;
   localparam int DMEM_NUM_REQ         = 2;
   localparam int DMEM_MAX_OUTSTANDING = 4;

   // Width needed to index a requester; at least one bit so the field always exists.
   localparam int ENTRY_OWNER_W = (DMEM_NUM_REQ > 1) ? $clog2(DMEM_NUM_REQ) : 1;

   // Width of a counter that must represent 0..max_out inclusive.
   function automatic int count_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

   localparam int COUNT_W = count_width(DMEM_MAX_OUTSTANDING);

   // One outstanding-load tracking entry.
   typedef struct packed {
      logic                     valid;
      logic [DMEM_XLEN-1:0]     address;
      logic [ENTRY_OWNER_W-1:0] owner;
   } table_entry_t;

endpackage

// File: rtl/dmem_load_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or above the
// pointer, wrapping around. Purely combinational.
module rr_arbiter #(
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  request,
   input  logic [IW-1:0] pointer,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_index,
   output logic          grant_valid
);

   // Scan offsets from farthest to nearest so the nearest active request wins.
   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_index = '0;
      grant_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(pointer) + k) % N;
         if (request[idx]) begin
            grant_index = IW'(idx);
            grant_valid = 1'b1;
         end
      end
      if (grant_valid) begin
         grant[grant_index] = 1'b1;
      end
   end

endmodule

// File: rtl/dmem_load_scheduler.sv
// Shares the dmem arbiter's single load port among several requesters.
// Requests are arbitrated round-robin, outstanding loads are tracked by
// address, and each response is routed back to the requester that issued it.
module dmem_load_scheduler
   import dmem_load_scheduler_pkg::*;
#(
   parameter int XLEN            = DMEM_XLEN,
   parameter int NUM_REQ         = DMEM_NUM_REQ,
   parameter int MAX_OUTSTANDING = DMEM_MAX_OUTSTANDING
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [NUM_REQ-1:0]                     req_valid,
   output logic [NUM_REQ-1:0]                     req_ready,
   input  logic [NUM_REQ*XLEN-1:0]                req_address,
   output logic [NUM_REQ-1:0]                     resp_valid,
   input  logic [NUM_REQ-1:0]                     resp_ready,
   output logic [XLEN-1:0]                        resp_address,
   output logic [XLEN-1:0]                        resp_value,
   output logic                                   load_request_valid,
   input  logic                                   load_request_ready,
   output logic [XLEN-1:0]                        load_request_address,
   input  logic                                   load_response_valid,
   output logic                                   load_response_ready,
   input  logic [XLEN-1:0]                        load_response_address,
   input  logic [XLEN-1:0]                        load_response_value,
   output logic [count_width(MAX_OUTSTANDING)-1:0] outstanding_count,
   output logic                                   unmatched_error
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W  = count_width(MAX_OUTSTANDING);

   genvar gi, ge;

   table_entry_t         entry_reg [MAX_OUTSTANDING];
   logic [IDX_W-1:0]     rr_ptr_reg;
   logic                 unmatched_error_reg;

   logic [CNT_W-1:0]     count_next;
   logic                 full;
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   grant_onehot;
   logic [IDX_W-1:0]     grant_idx;
   logic                 any_eligible;
   logic [IDX_W-1:0]     rr_ptr_next;
   logic [SLOT_W-1:0]    free_slot;
   logic [MAX_OUTSTANDING-1:0] resp_hit_vec;
   logic                 resp_hit;
   logic [SLOT_W-1:0]    hit_slot;
   logic [ENTRY_OWNER_W-1:0] hit_owner;
   logic                 req_fire;
   logic                 resp_fire;

   // Occupancy is the number of valid entries in the registered table.
   always_comb begin
      count_next = '0;
      for (int e = 0; e < MAX_OUTSTANDING; e++) begin
         count_next = count_next + CNT_W'(entry_reg[e].valid);
      end
   end

   assign outstanding_count = count_next;
   assign full              = (count_next == CNT_W'(MAX_OUTSTANDING));
   assign unmatched_error   = unmatched_error_reg;

   // A requester may only issue if its address is not already in flight.
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
         logic [MAX_OUTSTANDING-1:0] addr_hit;
         for (ge = 0; ge < MAX_OUTSTANDING; ge++) begin : g_cmp
            assign addr_hit[ge] = entry_reg[ge].valid &&
                                  (entry_reg[ge].address == req_address[gi*XLEN +: XLEN]);
         end
         assign eligible[gi] = req_valid[gi] && !(|addr_hit);
      end
   endgenerate

   rr_arbiter #(
      .N(NUM_REQ)
   ) u_rr_arbiter (
      .request     (eligible),
      .pointer     (rr_ptr_reg),
      .grant       (grant_onehot),
      .grant_index (grant_idx),
      .grant_valid (any_eligible)
   );

   assign load_request_valid   = any_eligible && !full;
   assign load_request_address = req_address[grant_idx*XLEN +: XLEN];
   assign req_ready            = grant_onehot & {NUM_REQ{load_request_ready && !full}};
   assign req_fire             = load_request_valid && load_request_ready;
   assign rr_ptr_next          = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // Lowest-index free slot; scanned top-down so the lowest index wins.
   always_comb begin
      free_slot = '0;
      for (int e = MAX_OUTSTANDING - 1; e >= 0; e--) begin
         if (!entry_reg[e].valid) begin
            free_slot = SLOT_W'(e);
         end
      end
   end

   // Full-width address match of the incoming response against the table.
   generate
      for (ge = 0; ge < MAX_OUTSTANDING; ge++) begin : g_resp_cmp
         assign resp_hit_vec[ge] = entry_reg[ge].valid &&
                                   (entry_reg[ge].address == load_response_address);
      end
   endgenerate

   // The hit is unique, so a simple priority scan recovers slot and owner.
   always_comb begin
      hit_slot  = '0;
      hit_owner = '0;
      for (int e = 0; e < MAX_OUTSTANDING; e++) begin
         if (resp_hit_vec[e]) begin
            hit_slot  = SLOT_W'(e);
            hit_owner = entry_reg[e].owner;
         end
      end
   end

   assign resp_hit = |resp_hit_vec;

   // Route the response to its owner; unmatched responses are sunk.
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp_route
         assign resp_valid[gi] = load_response_valid && resp_hit &&
                                 (hit_owner == ENTRY_OWNER_W'(gi));
      end
   endgenerate

   assign load_response_ready = resp_hit ? resp_ready[hit_owner] : 1'b1;
   assign resp_address        = load_response_address;
   assign resp_value          = load_response_value;
   assign resp_fire           = load_response_valid && load_response_ready;

   // Table, round-robin pointer and sticky error update.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int e = 0; e < MAX_OUTSTANDING; e++) begin
            entry_reg[e] <= '0;
         end
         rr_ptr_reg          <= '0;
         unmatched_error_reg <= 1'b0;
      end else begin
         // Free and allocate never target the same slot: one is valid, the other free.
         if (resp_fire && resp_hit) begin
            entry_reg[hit_slot].valid <= 1'b0;
         end
         if (req_fire) begin
            entry_reg[free_slot] <= '{valid:   1'b1,
                                      address: load_request_address,
                                      owner:   ENTRY_OWNER_W'(grant_idx)};
            rr_ptr_reg <= rr_ptr_next;
         end
         if (load_response_valid && !resp_hit) begin
            unmatched_error_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_load_scheduler.sv
// Directed, table-driven bench for dmem_load_scheduler.
module tb_dmem_load_scheduler;

   localparam int XLEN    = 64;
   localparam int NUM_REQ = 2;
   localparam int MAX_OUT = 4;

   logic                    clock;
   logic                    reset;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ*XLEN-1:0] req_address;
   logic [NUM_REQ-1:0]      resp_valid;
   logic [NUM_REQ-1:0]      resp_ready;
   logic [XLEN-1:0]         resp_address;
   logic [XLEN-1:0]         resp_value;
   logic                    load_request_valid;
   logic                    load_request_ready;
   logic [XLEN-1:0]         load_request_address;
   logic                    load_response_valid;
   logic                    load_response_ready;
   logic [XLEN-1:0]         load_response_address;
   logic [XLEN-1:0]         load_response_value;
   logic [2:0]              outstanding_count;
   logic                    unmatched_error;

   dmem_load_scheduler #(
      .XLEN(XLEN), .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .req_valid             (req_valid),
      .req_ready             (req_ready),
      .req_address           (req_address),
      .resp_valid            (resp_valid),
      .resp_ready            (resp_ready),
      .resp_address          (resp_address),
      .resp_value            (resp_value),
      .load_request_valid    (load_request_valid),
      .load_request_ready    (load_request_ready),
      .load_request_address  (load_request_address),
      .load_response_valid   (load_response_valid),
      .load_response_ready   (load_response_ready),
      .load_response_address (load_response_address),
      .load_response_value   (load_response_value),
      .outstanding_count     (outstanding_count),
      .unmatched_error       (unmatched_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  rv;
      logic [63:0] a0;
      logic [63:0] a1;
      logic        lrr;
      logic        rsv;
      logic [63:0] rsa;
      logic [63:0] rsd;
      logic [1:0]  rsr;
      logic        e_lrv;
      logic [63:0] e_addr;
      logic [1:0]  e_rdy;
      logic [1:0]  e_rsv;
      logic        e_lrsr;
      logic [2:0]  e_cnt;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];
   int   total_count = 0;
   int   pass_count  = 0;

   task automatic add(input logic [1:0] rv, input logic [63:0] a0, input logic [63:0] a1,
                      input logic lrr, input logic rsv, input logic [63:0] rsa,
                      input logic [63:0] rsd, input logic [1:0] rsr,
                      input logic e_lrv, input logic [63:0] e_addr, input logic [1:0] e_rdy,
                      input logic [1:0] e_rsv, input logic e_lrsr, input logic [2:0] e_cnt,
                      input logic e_err);
      vec_t v;
      v.rv = rv; v.a0 = a0; v.a1 = a1; v.lrr = lrr;
      v.rsv = rsv; v.rsa = rsa; v.rsd = rsd; v.rsr = rsr;
      v.e_lrv = e_lrv; v.e_addr = e_addr; v.e_rdy = e_rdy; v.e_rsv = e_rsv;
      v.e_lrsr = e_lrsr; v.e_cnt = e_cnt; v.e_err = e_err;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int step, input logic [63:0] act,
                      input logic [63:0] exp);
      total_count++;
      if (act === exp) begin
         pass_count++;
      end else begin
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] rv, input logic [63:0] a0, input logic [63:0] a1,
                        input logic lrr, input logic rsv, input logic [63:0] rsa,
                        input logic [63:0] rsd, input logic [1:0] rsr);
      req_valid             = rv;
      req_address           = {a1, a0};
      load_request_ready    = lrr;
      load_response_valid   = rsv;
      load_response_address = rsa;
      load_response_value   = rsd;
      resp_ready            = rsr;
   endtask

   task automatic drive_idle();
      drive(2'b00, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 2'b00);
   endtask

   initial begin
      // row: rv, a0, a1, lrr | rsv, rsa, rsd, rsr | lrv, addr, rdy, rsv, lrsr, cnt, err
      add(2'b00, 64'h0,   64'h0,   1, 0, 64'h0,   64'h0,    2'b00, 0, 64'h0,   2'b00, 2'b00, 1, 3'd0, 0); // reset state
      add(2'b11, 64'h100, 64'h200, 1, 0, 64'h0,   64'h0,    2'b00, 1, 64'h100, 2'b01, 2'b00, 1, 3'd0, 0); // grant r0
      add(2'b11, 64'h100, 64'h200, 1, 0, 64'h0,   64'h0,    2'b00, 1, 64'h200, 2'b10, 2'b00, 1, 3'd1, 0); // grant r1
      add(2'b11, 64'h140, 64'h240, 1, 0, 64'h0,   64'h0,    2'b00, 1, 64'h140, 2'b01, 2'b00, 1, 3'd2, 0); // r0 again
      add(2'b11, 64'h140, 64'h240, 1, 0, 64'h0,   64'h0,    2'b00, 1, 64'h240, 2'b10, 2'b00, 1, 3'd3, 0); // 4th issue
      add(2'b11, 64'h180, 64'h280, 1, 0, 64'h0,   64'h0,    2'b00, 0, 64'h0,   2'b00, 2'b00, 1, 3'd4, 0); // full
      add(2'b00, 64'h0,   64'h0,   1, 1, 64'h200, 64'hAAAA, 2'b11, 0, 64'h0,   2'b00, 2'b10, 1, 3'd4, 0); // resp 0x200
      add(2'b00, 64'h0,   64'h0,   1, 1, 64'h100, 64'hBBBB, 2'b11, 0, 64'h0,   2'b00, 2'b01, 1, 3'd3, 0); // resp 0x100
      add(2'b00, 64'h0,   64'h0,   1, 1, 64'h140, 64'hC140, 2'b10, 0, 64'h0,   2'b00, 2'b01, 0, 3'd2, 0); // backpressured
      add(2'b00, 64'h0,   64'h0,   1, 1, 64'h140, 64'hC140, 2'b01, 0, 64'h0,   2'b00, 2'b01, 1, 3'd2, 0); // accepted
      add(2'b10, 64'h0,   64'h240, 1, 0, 64'h0,   64'h0,    2'b00, 0, 64'h0,   2'b00, 2'b00, 1, 3'd1, 0); // addr busy
      add(2'b10, 64'h0,   64'h240, 1, 1, 64'h240, 64'hCCCC, 2'b10, 0, 64'h0,   2'b00, 2'b10, 1, 3'd1, 0); // freed, still blocked
      add(2'b10, 64'h0,   64'h240, 1, 0, 64'h0,   64'h0,    2'b00, 1, 64'h240, 2'b10, 2'b00, 1, 3'd0, 0); // now granted
      add(2'b00, 64'h0,   64'h0,   1, 1, 64'h300, 64'hDEAD, 2'b00, 0, 64'h0,   2'b00, 2'b00, 1, 3'd1, 0); // unmatched
      add(2'b00, 64'h0,   64'h0,   1, 0, 64'h0,   64'h0,    2'b00, 0, 64'h0,   2'b00, 2'b00, 1, 3'd1, 1); // sticky error
      add(2'b01, 64'h400, 64'h0,   0, 0, 64'h0,   64'h0,    2'b00, 1, 64'h400, 2'b00, 2'b00, 1, 3'd1, 1); // arbiter not ready
      add(2'b01, 64'h400, 64'h0,   1, 0, 64'h0,   64'h0,    2'b00, 1, 64'h400, 2'b01, 2'b00, 1, 3'd1, 1);
      add(2'b01, 64'h500, 64'h0,   1, 0, 64'h0,   64'h0,    2'b00, 1, 64'h500, 2'b01, 2'b00, 1, 3'd2, 1); // wrap to r0
      add(2'b11, 64'h600, 64'h700, 1, 0, 64'h0,   64'h0,    2'b00, 1, 64'h700, 2'b10, 2'b00, 1, 3'd3, 1); // rr favours r1
      add(2'b01, 64'h600, 64'h0,   1, 1, 64'h400, 64'hDDDD, 2'b01, 0, 64'h0,   2'b00, 2'b01, 1, 3'd4, 1); // full + free
      add(2'b01, 64'h600, 64'h0,   1, 0, 64'h0,   64'h0,    2'b00, 1, 64'h600, 2'b01, 2'b00, 1, 3'd3, 1); // accepted next
      add(2'b00, 64'h0,   64'h0,   1, 0, 64'h0,   64'h0,    2'b00, 0, 64'h0,   2'b00, 2'b00, 1, 3'd4, 1); // full again

      reset = 1'b1;
      drive_idle();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clock);
         #1;
         drive(vecs[i].rv, vecs[i].a0, vecs[i].a1, vecs[i].lrr,
               vecs[i].rsv, vecs[i].rsa, vecs[i].rsd, vecs[i].rsr);
         #3;
         chk("load_request_valid", i, load_request_valid, vecs[i].e_lrv);
         if (vecs[i].e_lrv) chk("load_request_address", i, load_request_address, vecs[i].e_addr);
         chk("req_ready", i, req_ready, vecs[i].e_rdy);
         chk("resp_valid", i, resp_valid, vecs[i].e_rsv);
         if (vecs[i].e_rsv != 2'b00) chk("resp_value", i, resp_value, vecs[i].rsd);
         chk("load_response_ready", i, load_response_ready, vecs[i].e_lrsr);
         chk("outstanding_count", i, outstanding_count, vecs[i].e_cnt);
         chk("unmatched_error", i, unmatched_error, vecs[i].e_err);
         $display("step %0d: rv=%b lrv=%b rdy=%b rsv=%b cnt=%0d err=%b", i, vecs[i].rv,
                  load_request_valid, req_ready, resp_valid, outstanding_count, unmatched_error);
      end

      // Reset with a full table: everything discarded, error cleared.
      @(posedge clock);
      #1 drive_idle(); reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      #3;
      chk("rst_count", 100, outstanding_count, 3'd0);
      chk("rst_err", 100, unmatched_error, 1'b0);
      chk("rst_lrv", 100, load_request_valid, 1'b0);
      $display("step 100: mid-run reset cnt=%0d err=%b", outstanding_count, unmatched_error);

      // Late response for a discarded load is dropped and flagged.
      @(posedge clock);
      #1 drive(2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 64'h600, 64'h6666, 2'b11);
      #3;
      chk("stale_resp_valid", 101, resp_valid, 2'b00);
      chk("stale_lresp_ready", 101, load_response_ready, 1'b1);
      chk("stale_err_pre", 101, unmatched_error, 1'b0);
      @(posedge clock);
      #1 drive_idle();
      #3;
      chk("stale_err_post", 102, unmatched_error, 1'b1);
      $display("step 102: stale response err=%b", unmatched_error);

      // Allocate and free in the same cycle while not full.
      @(posedge clock);
      #1 drive(2'b01, 64'h900, 64'h0, 1'b1, 1'b0, 64'h0, 64'h0, 2'b00);
      #3;
      chk("af_rdy0", 103, req_ready, 2'b01);
      @(posedge clock);
      #1 drive(2'b10, 64'h0, 64'hA00, 1'b1, 1'b1, 64'h900, 64'h1234, 2'b11);
      #3;
      chk("af_rsv", 104, resp_valid, 2'b01);
      chk("af_rdy1", 104, req_ready, 2'b10);
      chk("af_addr", 104, load_request_address, 64'hA00);
      chk("af_cnt_pre", 104, outstanding_count, 3'd1);
      @(posedge clock);
      #1 drive(2'b00, 64'h0, 64'h0, 1'b1, 1'b1, 64'hA00, 64'h5678, 2'b11);
      #3;
      chk("af_cnt_post", 105, outstanding_count, 3'd1);
      chk("af_rsv_a00", 105, resp_valid, 2'b10);
      @(posedge clock);
      #1 drive_idle();
      #3;
      chk("af_cnt_end", 106, outstanding_count, 3'd0);
      $display("step 106: alloc/free sequence cnt=%0d", outstanding_count);

      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
